// File: rtl/hwpe_stream_skid_slice_pkg.sv
// Shared HWPE stream definitions: slice occupancy states and an occupancy helper,
// reused by the skid slice and sibling buffers.
package hwpe_stream_package;

  // Encoding mirrors {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'b00,
    SLICE_ONE   = 2'b01,
    SLICE_TWO   = 2'b11
  } slice_state_e;

  function automatic logic [1:0] slice_count(input logic skid_valid, input logic main_valid);
    return {1'b0, skid_valid} + {1'b0, main_valid};
  endfunction

endpackage

// File: rtl/hwpe_stream_skid_slice_if.sv
// HWPE stream bundle: valid/ready handshake carrying a data word and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_skid_slice.sv
// Two-entry register slice: main register drives the output, skid register absorbs
// the beat accepted while the output stalls, so every output is a flop.
module hwpe_stream_skid_slice
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o,
  output logic [1:0]             occupancy_o
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  main_valid_q, main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic [STRB_WIDTH-1:0] main_strb_q,  main_strb_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic [STRB_WIDTH-1:0] skid_strb_q,  skid_strb_d;

  slice_state_e state;
  logic         push_ready;
  logic         push;
  logic         pop;

  assign state      = slice_state_e'({skid_valid_q, main_valid_q});
  // Ready depends only on a flop and reset, never on the downstream ready.
  assign push_ready = !skid_valid_q && !rst_i;
  assign push       = push_i.valid && push_ready;
  assign pop        = main_valid_q && pop_o.ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_strb_d  = main_strb_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_strb_d  = skid_strb_q;
    case (state)
      SLICE_EMPTY: begin
        if (push) begin
          main_valid_d = 1'b1;
          main_data_d  = push_i.data;
          main_strb_d  = push_i.strb;
        end
      end
      SLICE_ONE: begin
        if (push && pop) begin
          main_data_d = push_i.data;
          main_strb_d = push_i.strb;
        end else if (push) begin
          skid_valid_d = 1'b1;
          skid_data_d  = push_i.data;
          skid_strb_d  = push_i.strb;
        end else if (pop) begin
          main_valid_d = 1'b0;
        end
      end
      SLICE_TWO: begin
        if (pop) begin
          main_data_d  = skid_data_q;
          main_strb_d  = skid_strb_q;
          skid_valid_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
    main_data_q <= main_data_d;
    main_strb_q <= main_strb_d;
    skid_data_q <= skid_data_d;
    skid_strb_q <= skid_strb_d;
  end

  assign push_i.ready = push_ready;
  assign pop_o.valid  = main_valid_q;
  assign pop_o.data   = main_data_q;
  assign pop_o.strb   = main_strb_q;
  assign occupancy_o  = slice_count(skid_valid_q, main_valid_q);

`ifndef SYNTHESIS
  assert property (@(posedge clk_i)
      (DATA_WIDTH % 8 == 0) && ($bits(push_i.data) == DATA_WIDTH) &&
      ($bits(pop_o.data) == DATA_WIDTH) && ($bits(push_i.strb) == STRB_WIDTH) &&
      ($bits(pop_o.strb) == STRB_WIDTH))
    else $error("stream width mismatch");

  assert property (@(posedge clk_i) disable iff (rst_i) !(skid_valid_q && !main_valid_q))
    else $error("skid valid without main valid");

  assert property (@(posedge clk_i) disable iff (rst_i)
      (pop_o.valid && !pop_o.ready) |=> ($stable(pop_o.data) && $stable(pop_o.strb)))
    else $error("pop payload changed while stalled");
`endif

endmodule
